// File: rtl/rv_multicycle_ctrl_hs_pkg.sv
// Shared constants for the handshaking multicycle RV32I controller: opcodes,
// instType codes, FSM state encoding, trap causes and datapath select codes.
// Optional feature macro: RV_MULDIV_EN (adds the MULDIV_WAIT state).
package rv_multicycle_ctrl_hs_pkg;

  // RV32I major opcodes handled by the controller
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // instType codes, one per opcode class; 0 means "no class" (outside EXECUTE)
  localparam logic [3:0] INST_NONE  = 4'd0;
  localparam logic [3:0] INST_R     = 4'd1;
  localparam logic [3:0] INST_I     = 4'd2;
  localparam logic [3:0] INST_JALR  = 4'd3;
  localparam logic [3:0] INST_JAL   = 4'd4;
  localparam logic [3:0] INST_B     = 4'd5;
  localparam logic [3:0] INST_LOAD  = 4'd6;
  localparam logic [3:0] INST_STORE = 4'd7;
  localparam logic [3:0] INST_LUI   = 4'd8;
  localparam logic [3:0] INST_AUIPC = 4'd9;

  // Trap causes as seen on trapCause
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_BUS     = 2'b10;

  // aluSrcB selects
  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  // memToReg selects
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // Controller states; MULDIV_WAIT only exists when the option is built in
  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemAccess = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
`ifdef RV_MULDIV_EN
    ,
    StMulDivWait = 3'd6
`endif
  } state_e;

  // Map an opcode to its instType class; INST_NONE marks an illegal opcode
  function automatic logic [3:0] inst_type_of(logic [6:0] op);
    logic [3:0] t;
    case (op)
      OP_R:     t = INST_R;
      OP_I:     t = INST_I;
      OP_JALR:  t = INST_JALR;
      OP_JAL:   t = INST_JAL;
      OP_B:     t = INST_B;
      OP_LOAD:  t = INST_LOAD;
      OP_STORE: t = INST_STORE;
      OP_LUI:   t = INST_LUI;
      OP_AUIPC: t = INST_AUIPC;
      default:  t = INST_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_hs_if.sv
// Control/handshake bundle between the multicycle controller (master) and the
// decoder, memory and datapath (slave).
interface rv_multicycle_ctrl_hs_if;
  logic [6:0] opcode;
  logic       funct7b0;
  logic       memReady;
  logic       muldivDone;
  logic       instWrite;
  logic [3:0] instType;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic       memRead;
  logic       memWrite;
  logic [1:0] memToReg;
  logic       isFetch;
  logic       isJump;
  logic       isBranch;
  logic       trap;
  logic [1:0] trapCause;
  logic       muldivStart;

  modport master (
    input  opcode, funct7b0, memReady, muldivDone,
    output instWrite, instType, regWrite, aluSrcA, aluSrcB, memRead, memWrite,
           memToReg, isFetch, isJump, isBranch, trap, trapCause, muldivStart
  );

  modport slave (
    output opcode, funct7b0, memReady, muldivDone,
    input  instWrite, instType, regWrite, aluSrcA, aluSrcB, memRead, memWrite,
           memToReg, isFetch, isJump, isBranch, trap, trapCause, muldivStart
  );
endinterface

// File: rtl/rv_ctrl_wait_timer.sv
// Memory wait counter for the multicycle controller. Counts stalled cycles in
// FETCH/MEM_ACCESS and flags the cycle on which the bus timeout would fire.
module rv_ctrl_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RES,
  input  logic i_clear,
  input  logic i_count,
  output logic o_timeout
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  logic [TO_W-1:0] r_cnt;

  // Clear wins over count so a state change always restarts the wait window
  always_ff @(posedge CLK) begin
    if (RES || i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_timeout = (r_cnt == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv_multicycle_ctrl_hs.sv
// Multicycle RV32I control FSM with ready handshakes on fetch and data access,
// LUI/AUIPC decode, illegal-opcode trap and bus-timeout trap.
// Optional feature macro: RV_MULDIV_EN (R-type funct7b0 goes through the muldiv unit).
module rv_multicycle_ctrl_hs
  import rv_multicycle_ctrl_hs_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   CLK,
  input logic                   RES,
  rv_multicycle_ctrl_hs_if.master bus
);

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_trap_cause;
  logic [1:0] w_trap_cause_d;
  logic       w_timeout;
  logic       w_wait_clear;
  logic       w_wait_count;

  logic       w_inst_write;
  logic [3:0] w_inst_type;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_mem_read;
  logic       w_mem_write;
  logic [1:0] w_mem_to_reg;
  logic       w_is_fetch;
  logic       w_is_jump;
  logic       w_is_branch;
  logic       w_trap;
  logic       w_muldiv_start;

  // Wait counter restarts on every state change; counts only stalled memory cycles
  assign w_wait_clear = (w_state_d != r_state);
  assign w_wait_count = ((r_state == StFetch) || (r_state == StMemAccess)) && !bus.memReady;

  rv_ctrl_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .CLK      (CLK),
    .RES      (RES),
    .i_clear  (w_wait_clear),
    .i_count  (w_wait_count),
    .o_timeout(w_timeout)
  );

  // Next-state and trap-cause selection; memReady beats a coincident timeout
  always_comb begin
    w_state_d      = r_state;
    w_trap_cause_d = r_trap_cause;
    unique case (r_state)
      StFetch: begin
        if (bus.memReady) begin
          w_state_d = StDecode;
        end else if (w_timeout) begin
          w_state_d      = StTrap;
          w_trap_cause_d = TRAP_BUS;
        end
      end
      StDecode: w_state_d = StExecute;
      StExecute: begin
        case (bus.opcode)
          OP_R: begin
`ifdef RV_MULDIV_EN
            if (bus.funct7b0) begin
              w_state_d = StMulDivWait;
            end else begin
              w_state_d = StWriteback;
            end
`else
            w_state_d = StWriteback;
`endif
          end
          OP_I, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: w_state_d = StWriteback;
          OP_B:                                     w_state_d = StFetch;
          OP_LOAD, OP_STORE:                        w_state_d = StMemAccess;
          default: begin
            w_state_d      = StTrap;
            w_trap_cause_d = TRAP_ILLEGAL;
          end
        endcase
      end
      StMemAccess: begin
        if (bus.memReady) begin
          w_state_d = (bus.opcode == OP_STORE) ? StFetch : StWriteback;
        end else if (w_timeout) begin
          w_state_d      = StTrap;
          w_trap_cause_d = TRAP_BUS;
        end
      end
      StWriteback: w_state_d = StFetch;
      StTrap:      w_state_d = StFetch;
`ifdef RV_MULDIV_EN
      StMulDivWait: begin
        if (bus.muldivDone) begin
          w_state_d = StWriteback;
        end
      end
`endif
      default: w_state_d = StFetch;
    endcase
  end

  // State and trap-cause registers
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state      <= StFetch;
      r_trap_cause <= TRAP_NONE;
    end else begin
      r_state      <= w_state_d;
      r_trap_cause <= w_trap_cause_d;
    end
  end

  // Control outputs decoded from state/opcode; all forced low while in reset
  always_comb begin
    w_inst_write   = 1'b0;
    w_inst_type    = INST_NONE;
    w_reg_write    = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = ALUB_RS2;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_to_reg   = M2R_ALU;
    w_is_fetch     = 1'b0;
    w_is_jump      = 1'b0;
    w_is_branch    = 1'b0;
    w_trap         = 1'b0;
    w_muldiv_start = 1'b0;
    if (!RES) begin
      unique case (r_state)
        StFetch: begin
          w_mem_read   = 1'b1;
          w_inst_write = bus.memReady;
          w_is_fetch   = bus.memReady;
        end
        StExecute: begin
          w_inst_type = inst_type_of(bus.opcode);
          case (bus.opcode)
            OP_R: begin
`ifdef RV_MULDIV_EN
              w_muldiv_start = bus.funct7b0;
`endif
            end
            OP_I, OP_LOAD, OP_STORE, OP_LUI: w_alu_src_b = ALUB_IMM;
            OP_JALR: begin
              w_alu_src_b = ALUB_IMM;
              w_is_jump   = 1'b1;
            end
            OP_JAL: begin
              w_alu_src_a = 1'b1;
              w_alu_src_b = ALUB_IMM;
              w_is_jump   = 1'b1;
            end
            OP_B: w_is_branch = 1'b1;
            OP_AUIPC: begin
              w_alu_src_a = 1'b1;
              w_alu_src_b = ALUB_IMM;
            end
            default: ;
          endcase
        end
        StMemAccess: begin
          w_mem_read  = (bus.opcode == OP_LOAD);
          w_mem_write = (bus.opcode == OP_STORE);
        end
        StWriteback: begin
          w_reg_write = 1'b1;
          if (bus.opcode == OP_LOAD) begin
            w_mem_to_reg = M2R_MEM;
          end else if ((bus.opcode == OP_JAL) || (bus.opcode == OP_JALR)) begin
            w_mem_to_reg = M2R_PC4;
          end
        end
        StTrap: w_trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.instWrite = w_inst_write;
  assign bus.instType  = w_inst_type;
  assign bus.regWrite  = w_reg_write;
  assign bus.aluSrcA   = w_alu_src_a;
  assign bus.aluSrcB   = w_alu_src_b;
  assign bus.memRead   = w_mem_read;
  assign bus.memWrite  = w_mem_write;
  assign bus.memToReg  = w_mem_to_reg;
  assign bus.isFetch   = w_is_fetch;
  assign bus.isJump    = w_is_jump;
  assign bus.isBranch  = w_is_branch;
  assign bus.trap      = w_trap;
  assign bus.trapCause = RES ? TRAP_NONE : r_trap_cause;

`ifdef RV_MULDIV_EN
  assign bus.muldivStart = w_muldiv_start;
`else
  // Option absent: muldiv inputs are deliberately ignored
  logic w_unused_muldiv;
  assign w_unused_muldiv = bus.funct7b0 ^ bus.muldivDone ^ w_muldiv_start;
  assign bus.muldivStart = 1'b0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl_hs.sv
// Randomized self-checking bench for rv_multicycle_ctrl_hs. Each instruction is
// planned as a sequence of phases (fetch, decode, execute, memory, writeback,
// trap) whose expected outputs come from the opcode-class table below.
module tb_rv_multicycle_ctrl_hs;

  localparam int unsigned TO = 4;

  localparam logic [6:0] C_R     = 7'b0110011;
  localparam logic [6:0] C_I     = 7'b0010011;
  localparam logic [6:0] C_JALR  = 7'b1100111;
  localparam logic [6:0] C_JAL   = 7'b1101111;
  localparam logic [6:0] C_B     = 7'b1100011;
  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0100011;
  localparam logic [6:0] C_LUI   = 7'b0110111;
  localparam logic [6:0] C_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       iw;
    logic [3:0] it;
    logic       rw;
    logic       a;
    logic [1:0] b;
    logic       mr;
    logic       mw;
    logic [1:0] m2r;
    logic       f;
    logic       j;
    logic       br;
    logic       tr;
    logic [1:0] tc;
    logic       ms;
  } ov_t;

  logic CLK = 1'b0;
  logic RES;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [1:0] m_cause = 2'b00;

  always #5 CLK = ~CLK;

  rv_multicycle_ctrl_hs_if bus ();

  rv_multicycle_ctrl_hs #(
    .MEM_TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(bus)
  );

  function automatic ov_t observe();
    ov_t o;
    o.iw  = bus.instWrite;
    o.it  = bus.instType;
    o.rw  = bus.regWrite;
    o.a   = bus.aluSrcA;
    o.b   = bus.aluSrcB;
    o.mr  = bus.memRead;
    o.mw  = bus.memWrite;
    o.m2r = bus.memToReg;
    o.f   = bus.isFetch;
    o.j   = bus.isJump;
    o.br  = bus.isBranch;
    o.tr  = bus.trap;
    o.tc  = bus.trapCause;
    o.ms  = bus.muldivStart;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already driven; sample on the falling edge, then advance one cycle
  task automatic cyc(input string tag, input ov_t e);
    @(negedge CLK);
    check_eq(tag, {12'b0, observe()}, {12'b0, e});
    @(posedge CLK);
    #1;
  endtask

  // Opcode class per the instType ordering; 0 = illegal
  function automatic int cls(input logic [6:0] op);
    case (op)
      C_R:     return 1;
      C_I:     return 2;
      C_JALR:  return 3;
      C_JAL:   return 4;
      C_B:     return 5;
      C_LOAD:  return 6;
      C_STORE: return 7;
      C_LUI:   return 8;
      C_AUIPC: return 9;
      default: return 0;
    endcase
  endfunction

  task automatic trap_cycle(input logic [1:0] cause);
    ov_t e;
    m_cause      = cause;
    bus.memReady = 1'($urandom);
    e            = '0;
    e.tr         = 1'b1;
    e.tc         = m_cause;
    cyc("trap", e);
  endtask

  // fw/mw: stall cycles before memReady; dw: muldiv busy cycles;
  // abort_at: MEM_ACCESS cycle index at which reset is asserted (-1 = never)
  task automatic run_instr(input logic [6:0] op, input logic f7, input int fw, input int mw,
                           input int dw, input int abort_at);
    int   c;
    bit   done;
    ov_t  e;
    c              = cls(op);
    bus.opcode     = op;
    bus.funct7b0   = f7;
    bus.muldivDone = 1'($urandom);
    // fetch
    done = 0;
    for (int i = 0; i < int'(TO) && !done; i++) begin
      bus.memReady = (i == fw);
      e    = '0;
      e.mr = 1'b1;
      e.iw = (i == fw);
      e.f  = (i == fw);
      e.tc = m_cause;
      cyc("fetch", e);
      if (i == fw) done = 1;
    end
    if (!done) begin
      trap_cycle(2'b10);
      return;
    end
    // decode
    bus.memReady = 1'($urandom);
    e    = '0;
    e.tc = m_cause;
    cyc("decode", e);
    // execute
    bus.memReady = 1'($urandom);
    e    = '0;
    e.tc = m_cause;
    e.it = 4'(c);
    e.b  = (c == 2 || c == 3 || c == 4 || c == 6 || c == 7 || c == 8 || c == 9) ? 2'b01 : 2'b00;
    e.a  = (c == 4 || c == 9);
    e.j  = (c == 3 || c == 4);
    e.br = (c == 5);
`ifdef RV_MULDIV_EN
    e.ms = (c == 1) && f7;
`endif
    cyc("exec", e);
    if (c == 0) begin
      trap_cycle(2'b01);
      return;
    end
    if (c == 5) return;
`ifdef RV_MULDIV_EN
    if (c == 1 && f7) begin
      for (int k = 0; k <= dw; k++) begin
        bus.muldivDone = (k == dw);
        bus.memReady   = 1'($urandom);
        e    = '0;
        e.tc = m_cause;
        cyc("mdwait", e);
      end
    end
`endif
    if (c == 6 || c == 7) begin
      done = 0;
      for (int i = 0; i < int'(TO) && !done; i++) begin
        if (i == abort_at) begin
          RES          = 1'b1;
          bus.memReady = 1'($urandom);
          e            = '0;
          cyc("rst_mem", e);
          RES     = 1'b0;
          m_cause = 2'b00;
          return;
        end
        bus.memReady = (i == mw);
        e    = '0;
        e.mr = (c == 6);
        e.mw = (c == 7);
        e.tc = m_cause;
        cyc("mem", e);
        if (i == mw) done = 1;
      end
      if (!done) begin
        trap_cycle(2'b10);
        return;
      end
      if (c == 7) return;
    end
    // writeback
    bus.memReady = 1'($urandom);
    e     = '0;
    e.rw  = 1'b1;
    e.m2r = (c == 6) ? 2'b01 : ((c == 3 || c == 4) ? 2'b10 : 2'b00);
    e.tc  = m_cause;
    cyc("wb", e);
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 6) == 0) return int'($urandom_range(0, TO + 1));
    return int'($urandom_range(0, 1));
  endfunction

  initial begin
    logic [6:0] legal [9];
    logic [6:0] op;
    int         r;
    int         ab;
    ov_t        z;
    legal = '{C_R, C_I, C_JALR, C_JAL, C_B, C_LOAD, C_STORE, C_LUI, C_AUIPC};
    z = '0;

    RES            = 1'b1;
    bus.opcode     = C_STORE;
    bus.funct7b0   = 1'b1;
    bus.memReady   = 1'b1;
    bus.muldivDone = 1'b1;
    #1;
    cyc("reset0", z);
    cyc("reset1", z);
    RES = 1'b0;

    // Directed cases
    run_instr(C_R, 1'b0, 0, 0, 0, -1);
    run_instr(C_LOAD, 1'b0, 0, 3, 0, -1);
    run_instr(C_R, 1'b0, 10, 0, 0, -1);         // fetch timeout
    run_instr(C_I, 1'b0, TO - 1, 0, 0, -1);     // ready on the timeout cycle
    run_instr(7'b1111111, 1'b0, 0, 0, 0, -1);   // illegal opcode
    run_instr(C_STORE, 1'b0, 0, 5, 0, 1);       // reset during MEM_ACCESS
    run_instr(C_STORE, 1'b0, 0, TO - 1, 0, -1);
    run_instr(C_LOAD, 1'b0, 0, TO, 0, -1);      // data timeout
    run_instr(C_JAL, 1'b0, 0, 0, 0, -1);
    run_instr(C_AUIPC, 1'b0, 1, 0, 0, -1);
    run_instr(C_B, 1'b0, 0, 0, 0, -1);
    run_instr(C_R, 1'b1, 0, 0, 5, -1);          // muldiv select

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 10));
      if (r < 9) op = legal[r];
      else op = 7'($urandom);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr(op, 1'($urandom), rand_wait(), rand_wait(), int'($urandom_range(0, 4)), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
